// File: rtl/rv64g_l2_array_bank.sv
// L2 storage bank: data, tag and valid arrays behind a valid/ready request port,
// with a post-reset valid-clear sweep, parallel tag lookup and a full-line read burst.
module rv64g_l2_array_bank #(
  parameter int WAYS   = 16,
  parameter int SETS   = 256,
  parameter int WORDS  = 8,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 50,
  parameter int IDX_W  = $clog2(SETS),
  parameter int WAY_W  = $clog2(WAYS),
  parameter int WRD_W  = $clog2(WORDS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [2:0]          req_op_i,
  input  logic [IDX_W-1:0]    req_index_i,
  input  logic [WRD_W-1:0]    req_word_i,
  input  logic [WAY_W-1:0]    req_way_i,
  input  logic [TAG_W-1:0]    req_tag_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_hit_o,
  output logic                rsp_multihit_o,
  output logic [WAY_W-1:0]    rsp_way_o,
  output logic [DATA_W-1:0]   rsp_data_o,
  output logic                rsp_last_o,
  output logic                init_done_o
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [2:0] OP_LOOKUP     = 3'd0;
  localparam logic [2:0] OP_WRITE_WORD = 3'd1;
  localparam logic [2:0] OP_WRITE_TAG  = 3'd2;
  localparam logic [2:0] OP_READ_LINE  = 3'd3;
  localparam logic [2:0] OP_INVALIDATE = 3'd4;
  localparam logic [IDX_W-1:0] LAST_SET  = IDX_W'(SETS - 1);
  localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(WORDS - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BURST} state_e;
  state_e state_q, state_d;

  logic [DATA_W-1:0] data_mem  [WAYS*SETS*WORDS];
  logic [TAG_W-1:0]  tag_mem   [WAYS*SETS];
  logic [WAYS-1:0]   valid_mem [SETS];

  logic [IDX_W-1:0] init_cnt_q;
  logic [WRD_W-1:0] beat_q, beat_nx;
  logic [WAY_W-1:0] bway_q;
  logic [IDX_W-1:0] bidx_q;

  logic req_fire, rsp_fire;
  logic [WAYS-1:0]   match;
  logic [WAY_W-1:0]  hit_way;
  logic              lk_hit, lk_multi;
  logic [DATA_W-1:0] lk_data;

  // Handshake: a request transfers on req_valid_i & req_ready_o at posedge; a response
  // transfers on rsp_valid_o & rsp_ready_i. Every op waits for a free response slot so
  // writes cannot overtake an outstanding lookup.
  assign rsp_fire    = rsp_valid_o && rsp_ready_i;
  assign req_ready_o = (state_q == ST_IDLE) && (!rsp_valid_o || rsp_ready_i);
  assign req_fire    = req_valid_i && req_ready_o;
  assign beat_nx     = beat_q + WRD_W'(1);
  assign init_done_o = (state_q != ST_INIT) && !rst_i ? 1'b1 : 1'b0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (init_cnt_q == LAST_SET) state_d = ST_IDLE;
      ST_IDLE:  if (req_fire && req_op_i == OP_READ_LINE) state_d = ST_BURST;
      ST_BURST: if (rsp_fire && beat_q == LAST_BEAT) state_d = ST_IDLE;
      default:  state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // Lowest matching way wins; the x & (x-1) test flags two or more matches.
  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      match[w] = valid_mem[req_index_i][w] &&
                 (tag_mem[{WAY_W'(w), req_index_i}] == req_tag_i);
    for (int w = WAYS - 1; w >= 0; w--)
      if (match[w]) hit_way = WAY_W'(w);
    lk_hit   = |match;
    lk_multi = |(match & (match - WAYS'(1)));
    lk_data  = lk_hit ? data_mem[{hit_way, req_index_i, req_word_i}] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == ST_INIT) valid_mem[init_cnt_q] <= '0;
      if (req_fire) begin
        case (req_op_i)
          OP_WRITE_WORD:
            for (int b = 0; b < BE_W; b++)
              if (req_be_i[b])
                data_mem[{req_way_i, req_index_i, req_word_i}][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
          OP_WRITE_TAG: begin
            tag_mem[{req_way_i, req_index_i}] <= req_tag_i;
            valid_mem[req_index_i][req_way_i] <= 1'b1;
          end
          OP_INVALIDATE: valid_mem[req_index_i][req_way_i] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      init_cnt_q     <= '0;
      beat_q         <= '0;
      bway_q         <= '0;
      bidx_q         <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_hit_o      <= 1'b0;
      rsp_multihit_o <= 1'b0;
      rsp_way_o      <= '0;
      rsp_data_o     <= '0;
      rsp_last_o     <= 1'b0;
    end else begin
      if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + IDX_W'(1);
      if (rsp_fire) rsp_valid_o <= 1'b0;
      if (state_q == ST_BURST && rsp_fire && beat_q != LAST_BEAT) begin
        beat_q      <= beat_nx;
        rsp_valid_o <= 1'b1;
        rsp_data_o  <= data_mem[{bway_q, bidx_q, beat_nx}];
        rsp_last_o  <= (beat_nx == LAST_BEAT);
      end
      if (req_fire) begin
        case (req_op_i)
          OP_LOOKUP: begin
            rsp_valid_o    <= 1'b1;
            rsp_hit_o      <= lk_hit;
            rsp_multihit_o <= lk_multi;
            rsp_way_o      <= hit_way;
            rsp_data_o     <= lk_data;
            rsp_last_o     <= 1'b1;
          end
          OP_READ_LINE: begin
            beat_q         <= '0;
            bway_q         <= req_way_i;
            bidx_q         <= req_index_i;
            rsp_valid_o    <= 1'b1;
            rsp_hit_o      <= 1'b1;
            rsp_multihit_o <= 1'b0;
            rsp_way_o      <= req_way_i;
            rsp_data_o     <= data_mem[{req_way_i, req_index_i, WRD_W'(0)}];
            rsp_last_o     <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
